// File: rtl/piso_serial_tx_if.sv
// Parallel-load and serial-output bundle for piso_serial_tx.
// A word moves on a rising edge where load_valid && load_ready; load_ready never depends on load_valid.
interface piso_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             bit_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output data_in, load_valid,
    input  load_ready, serial_out, bit_valid, frame_start, frame_done, busy
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, serial_out, bit_valid, frame_start, frame_done, busy
  );
endinterface

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter with a one-word holding register so
// consecutive frames can be streamed without bubbles.
module piso_serial_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  piso_serial_tx_if.slave     bus,
  output logic [1:0]          dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [7:0]       gap_cnt, gap_cnt_n;
  logic             so_q, so_n;
  logic             bv_q, bv_n;
  logic             fs_q, fs_n;
  logic             fd_q, fd_n;
  logic             accept;
  logic             start;
  logic [WIDTH-1:0] start_word;
  logic [CW-1:0]    next_idx;

  function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
    if (MSB_FIRST) return w[LAST_BIT - idx];
    else           return w[idx];
  endfunction

  assign accept   = bus.load_valid && !hold_full;
  assign next_idx = bit_cnt + 1'b1;

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    bit_cnt_n   = bit_cnt;
    gap_cnt_n   = gap_cnt;
    so_n        = 1'b0;
    bv_n        = 1'b0;
    fs_n        = 1'b0;
    fd_n        = 1'b0;
    start       = 1'b0;
    start_word  = bus.data_in;

    case (state)
      IDLE: begin
        // A word can be left in hold when it arrived on the final gap edge.
        if (hold_full) begin
          start       = 1'b1;
          start_word  = hold;
          hold_full_n = 1'b0;
        end else if (accept) begin
          start = 1'b1;
        end
      end
      SHIFT: begin
        if (accept) begin
          hold_n      = bus.data_in;
          hold_full_n = 1'b1;
        end
        if (bit_cnt == LAST_BIT) begin
          if (GAP_CYCLES == 0 && hold_full) begin
            start       = 1'b1;
            start_word  = hold;
            hold_full_n = 1'b0;
          end else if (GAP_CYCLES > 0) begin
            state_n   = GAP;
            gap_cnt_n = 8'd0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_cnt_n = next_idx;
          so_n      = bit_at(shreg, next_idx);
          bv_n      = 1'b1;
          fd_n      = (next_idx == LAST_BIT);
        end
      end
      GAP: begin
        if (accept) begin
          hold_n      = bus.data_in;
          hold_full_n = 1'b1;
        end
        if (gap_cnt == GAP_LAST) begin
          if (hold_full) begin
            start       = 1'b1;
            start_word  = hold;
            hold_full_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_cnt_n = gap_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      state_n   = SHIFT;
      shreg_n   = start_word;
      bit_cnt_n = '0;
      so_n      = bit_at(start_word, '0);
      bv_n      = 1'b1;
      fs_n      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= 8'd0;
      so_q      <= 1'b0;
      bv_q      <= 1'b0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      so_q      <= so_n;
      bv_q      <= bv_n;
      fs_q      <= fs_n;
      fd_q      <= fd_n;
    end
  end

  assign bus.load_ready  = !hold_full;
  assign bus.serial_out  = so_q;
  assign bus.bit_valid   = bv_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;
  assign bus.busy        = (state != IDLE) || hold_full;
  assign dbg_state       = state;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: MSB/LSB order, back-to-back, gap,
// hold-full back-pressure and mid-frame reset.
module tb_piso_serial_tx;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  piso_serial_tx_if #(.WIDTH(8)) ifa ();
  piso_serial_tx_if #(.WIDTH(8)) ifb ();
  piso_serial_tx_if #(.WIDTH(8)) ifc ();
  logic [1:0] dbg_a, dbg_b, dbg_c;

  piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .dbg_state(dbg_a));
  piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .dbg_state(dbg_b));
  piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc.slave), .dbg_state(dbg_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // scoreboard
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  logic       mon_en;
  int         fs_cnt, fd_cnt;

  always @(negedge clk) begin
    if (mon_en && ifa.bit_valid) begin
      got_q.push_back(ifa.serial_out);
      if (ifa.frame_start) fs_cnt++;
      if (ifa.frame_done)  fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int i);
    case (i)
      0:       return ifa.load_ready;
      1:       return ifb.load_ready;
      default: return ifc.load_ready;
    endcase
  endfunction

  // {serial_out, bit_valid, frame_start, frame_done}
  function automatic logic [3:0] obits(input int i);
    case (i)
      0:       return {ifa.serial_out, ifa.bit_valid, ifa.frame_start, ifa.frame_done};
      1:       return {ifb.serial_out, ifb.bit_valid, ifb.frame_start, ifb.frame_done};
      default: return {ifc.serial_out, ifc.bit_valid, ifc.frame_start, ifc.frame_done};
    endcase
  endfunction

  // driver tasks
  task automatic drive(input int i, input logic v, input logic [7:0] d);
    case (i)
      0:       begin ifa.load_valid = v; ifa.data_in = d; end
      1:       begin ifb.load_valid = v; ifb.data_in = d; end
      default: begin ifc.load_valid = v; ifc.data_in = d; end
    endcase
  endtask

  // Returns at the negedge right after the accept edge.
  task automatic send(input int i, input logic [7:0] w);
    int n;
    n = 0;
    drive(i, 1'b1, w);
    while (!rdy(i) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(rdy(i)), 32'd1);
    @(negedge clk);
    drive(i, 1'b0, w);
  endtask

  // seq[7] is the first bit expected on the line.
  task automatic expect_frame(input int i, input logic [7:0] seq, input string tag);
    for (int k = 0; k < 8; k++) begin
      check(tag, 32'(obits(i)), 32'({seq[7-k], 1'b1, k == 0, k == 7}));
      @(negedge clk);
    end
    check({tag, "_after"}, 32'(obits(i)), 32'd0);
  endtask

  initial begin
    logic [15:0] seq16;
    logic [7:0]  words [3];
    int          n;
    n_checks = 0;
    n_err    = 0;
    mon_en   = 1'b0;
    fs_cnt   = 0;
    fd_cnt   = 0;
    rst      = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    repeat (3) @(negedge clk);

    // reset state
    check("rst_outs_a", 32'(obits(0)), 32'd0);
    check("rst_outs_b", 32'(obits(1)), 32'd0);
    check("rst_outs_c", 32'(obits(2)), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_ready", 32'(ifa.load_ready), 32'd1);
    check("rst_state", 32'(dbg_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // MSB first, data_in changed after accept must not matter
    send(0, 8'hB2);
    drive(0, 1'b0, 8'h5A);
    expect_frame(0, 8'b10110010, "msb_b2");
    check("msb_b2_busy", 32'(ifa.busy), 32'd0);

    // LSB first
    send(1, 8'hB2);
    expect_frame(1, 8'b01001101, "lsb_b2");
    check("lsb_b2_busy", 32'(ifb.busy), 32'd0);

    // back-to-back with 2-cycle gap
    seq16 = 16'b1010_0101_0011_1100;
    send(2, 8'hA5);
    drive(2, 1'b1, 8'h3C);
    for (int c = 0; c < 18; c++) begin
      if (c < 8) begin
        check("gap_bits", 32'(obits(2)), 32'({seq16[15-c], 1'b1, c == 0, c == 7}));
      end else if (c < 10) begin
        check("gap_idle", 32'(obits(2)), 32'd0);
        check("gap_state", 32'(dbg_c), 32'd2);
        check("gap_busy", 32'(ifc.busy), 32'd1);
      end else begin
        check("gap_bits2", 32'(obits(2)), 32'({seq16[17-c], 1'b1, c == 10, c == 17}));
      end
      check("gap_ready", 32'(rdy(2)), 32'(c == 0 || c >= 10));
      @(negedge clk);
      if (c == 0) drive(2, 1'b0, 8'h3C);
    end
    check("gap_end", 32'(obits(2)), 32'd0);

    // back-to-back contiguous, no gap
    send(0, 8'hA5);
    drive(0, 1'b1, 8'h3C);
    for (int k = 0; k < 16; k++) begin
      check("b2b_bits", 32'(obits(0)), 32'({seq16[15-k], 1'b1, k == 0 || k == 8, k == 7 || k == 15}));
      check("b2b_ready", 32'(rdy(0)), 32'(k == 0 || k >= 8));
      @(negedge clk);
      if (k == 0) drive(0, 1'b0, 8'h3C);
    end
    check("b2b_end", 32'(obits(0)), 32'd0);
    check("b2b_busy", 32'(ifa.busy), 32'd0);

    // hold full back-pressure across three frames
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    exp_q.delete();
    got_q.delete();
    foreach (words[w]) for (int b = 7; b >= 0; b--) exp_q.push_back(words[w][b]);
    fs_cnt = 0;
    fd_cnt = 0;
    mon_en = 1'b1;
    send(0, words[0]);
    send(0, words[1]);
    check("hold_full_ready", 32'(rdy(0)), 32'd0);
    send(0, words[2]);
    n = 0;
    while ((ifa.busy || ifa.bit_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_idle", 32'(ifa.busy), 32'd0);
    mon_en = 1'b0;
    check("hold_nbits", 32'(got_q.size()), 32'd24);
    check("hold_frames", 32'(fs_cnt), 32'd3);
    check("hold_dones", 32'(fd_cnt), 32'd3);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("hold_bit", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));

    // reset mid-frame with a held word
    send(0, 8'hFF);
    drive(0, 1'b1, 8'h0F);
    @(negedge clk);
    drive(0, 1'b0, 8'h0F);
    check("pre_rst_ready", 32'(rdy(0)), 32'd0);
    repeat (2) @(negedge clk);
    check("bit4", 32'(obits(0)), 32'({1'b1, 1'b1, 1'b0, 1'b0}));
    rst = 1'b1;
    #1;
    check("rst_mid_outs", 32'(obits(0)), 32'd0);
    check("rst_mid_busy", 32'(ifa.busy), 32'd0);
    check("rst_mid_ready", 32'(ifa.load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    fd_cnt = 0;
    mon_en = 1'b1;
    repeat (12) @(negedge clk);
    mon_en = 1'b0;
    check("no_remnant_bits", 32'(got_q.size()), 32'd0);
    check("no_remnant_busy", 32'(ifa.busy), 32'd0);
    send(0, 8'h81);
    expect_frame(0, 8'b10000001, "post_rst_81");
    check("post_rst_busy", 32'(ifa.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
